// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit accesses on an
// asynchronous SRAM, low half first. The pipeline freezes while ready is low.
module sram_controller #(
  parameter int ADDRESS_LEN   = 32,
  parameter int DATA_LEN      = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int BASE_ADDRESS  = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [DATA_LEN-1:0]      write_data,
  output logic [DATA_LEN-1:0]      read_data,
  output logic                     ready,
  inout  wire  [SRAM_DATA_LEN-1:0] sram_dq,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [SRAM_ADDR_LEN:0] BASE_LOW = (SRAM_ADDR_LEN + 1)'(BASE_ADDRESS);

  state_t                   state;
  logic [CW-1:0]            counter;
  logic                     wr_q;
  logic [SRAM_DATA_LEN-1:0] wdata_hi;
  logic [SRAM_DATA_LEN-1:0] dq_out;
  logic                     dq_oe;
  logic [SRAM_ADDR_LEN:0]   offset;
  logic                     unused_bits;

  // Only the low bits of the rebased address reach the pins, so the
  // subtraction is done on that slice alone; borrows never flow upward.
  assign offset      = address[SRAM_ADDR_LEN:0] - BASE_LOW;
  assign unused_bits = ^{address[ADDRESS_LEN-1:SRAM_ADDR_LEN+1], offset[1:0]};

  assign sram_dq = dq_oe ? dq_out : {SRAM_DATA_LEN{1'bz}};
  assign ready   = (state == IDLE) ? ~(rd_en | wr_en) : (state == DONE);

  // Pin registers are loaded on the edge that enters a state, so every SRAM
  // control comes straight from a flop and never from the request inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      read_data <= '0;
      wr_q      <= 1'b0;
      wdata_hi  <= '0;
      dq_out    <= '0;
      dq_oe     <= 1'b0;
      sram_addr <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            state     <= LOW;
            counter   <= '0;
            wr_q      <= wr_en;
            wdata_hi  <= write_data[DATA_LEN-1:SRAM_DATA_LEN];
            dq_out    <= write_data[SRAM_DATA_LEN-1:0];
            dq_oe     <= wr_en;
            sram_addr <= {offset[SRAM_ADDR_LEN:2], 1'b0};
            sram_we_n <= ~wr_en;
            sram_oe_n <= wr_en;
            sram_ce_n <= 1'b0;
            sram_ub_n <= 1'b0;
            sram_lb_n <= 1'b0;
          end
        end
        LOW: begin
          if (counter == LAST) begin
            counter      <= '0;
            state        <= HIGH;
            sram_addr[0] <= 1'b1;
            dq_out       <= wdata_hi;
            if (!wr_q) read_data[SRAM_DATA_LEN-1:0] <= sram_dq;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        HIGH: begin
          if (counter == LAST) begin
            counter   <= '0;
            state     <= DONE;
            dq_oe     <= 1'b0;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            if (!wr_q) read_data[DATA_LEN-1:SRAM_DATA_LEN] <= sram_dq;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: an SRAM device model on the pins plus a
// transaction-level reference model, directed literal checks and random traffic.
module tb_sram_controller;

  localparam int AC   = 2;
  localparam int BASE = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] sram_mem  [0:262143];
  logic [15:0] model_mem [0:262143];

  bit          m_busy = 1'b0;
  bit          m_wr   = 1'b0;
  int          m_k    = 0;
  logic [17:0] m_hw   = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rd   = '0;

  logic [15:0] probe = 16'h5A3C;
  logic        bench_en;
  logic [15:0] bench_val;

  always #5 clk = ~clk;

  sram_controller #(
    .ADDRESS_LEN(32), .DATA_LEN(32), .SRAM_ADDR_LEN(18), .SRAM_DATA_LEN(16),
    .BASE_ADDRESS(BASE), .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  // Word address -> half-word index of its low half, wrapping below BASE.
  function automatic logic [17:0] halfBase(input logic [31:0] a);
    logic [31:0] w;
    w = ((a - BASE) >> 2) & 32'h1FFFF;
    return {w[16:0], 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rd_en      = r;
    wr_en      = w;
    address    = a;
    write_data = d;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20 && m_busy; i++) applyStimulus(0, 0, 32'h0, 32'h0);
    checkOutput("idle_timeout", {31'b0, m_busy}, 32'h0);
  endtask

  // Asynchronous SRAM device: a write lands while CE and WE are both low.
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
      if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
    end
  end

  always @(posedge clk) probe <= 16'($urandom);

  // Bench drives the bus whenever the controller must not: SRAM read data
  // when the pins select a read, otherwise a random probe word.
  always_comb begin
    bench_en  = !(m_busy && m_wr && m_k <= 2 * AC);
    bench_val = probe;
    if (!sram_ce_n && !sram_oe_n && sram_we_n) bench_val = sram_mem[sram_addr];
  end
  assign sram_dq = bench_en ? bench_val : 16'hzzzz;

  // Transaction model: m_k counts cycles since acceptance, 1..AC is the low
  // half, AC+1..2AC the high half and 2AC+1 the single ready cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_rd   = '0;
    end else if (!m_busy) begin
      if (rd_en || wr_en) begin
        m_busy  = 1'b1;
        m_k     = 1;
        m_wr    = wr_en;
        m_hw    = halfBase(address);
        m_wdata = write_data;
      end
    end else begin
      if (m_k == AC) begin
        if (m_wr) model_mem[m_hw] = m_wdata[15:0];
        else      m_rd[15:0]      = model_mem[m_hw];
      end
      if (m_k == 2 * AC) begin
        if (m_wr) model_mem[m_hw + 18'd1] = m_wdata[31:16];
        else      m_rd[31:16]             = model_mem[m_hw + 18'd1];
      end
      if (m_k == 2 * AC + 1) m_busy = 1'b0;
      else                   m_k++;
    end
  end

  always @(negedge clk) begin
    int  ph;
    bit  act;
    #1;
    ph  = !m_busy ? 0 : (m_k <= AC) ? 1 : (m_k <= 2 * AC) ? 2 : 3;
    act = (ph == 1) || (ph == 2);
    checkOutput("ready", {31'b0, ready}, {31'b0, (ph == 0) ? !(rd_en || wr_en) : (ph == 3)});
    checkOutput("ce_n", {31'b0, sram_ce_n}, {31'b0, !act});
    checkOutput("ub_lb_n", {30'b0, sram_ub_n, sram_lb_n}, {30'b0, !act, !act});
    checkOutput("we_n", {31'b0, sram_we_n}, {31'b0, !(act && m_wr)});
    checkOutput("oe_n", {31'b0, sram_oe_n}, {31'b0, !(act && !m_wr)});
    checkOutput("read_data", read_data, m_rd);
    if (act) checkOutput("sram_addr", {14'b0, sram_addr}, {14'b0, m_hw + ((ph == 2) ? 18'd1 : 18'd0)});
    if (act && m_wr) checkOutput("dq_write", {16'b0, sram_dq}, {16'b0, (ph == 1) ? m_wdata[15:0] : m_wdata[31:16]});
    else             checkOutput("dq_release", {16'b0, sram_dq}, {16'b0, bench_val});
  end

  initial begin
    for (int i = 0; i < 262144; i++) begin
      sram_mem[i]  = '0;
      model_mem[i] = '0;
    end
    rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1032; write_data = 32'h0;

    // Reset holds everything quiet even with a store pending.
    repeat (3) begin
      @(negedge clk); #2;
      checkOutput("rst_ready", {31'b0, ready}, 32'h0);
      checkOutput("rst_ctrl_n", {27'b0, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h1F);
      checkOutput("rst_addr", {14'b0, sram_addr}, 32'h0);
      checkOutput("rst_read_data", read_data, 32'h0);
    end
    @(negedge clk); rst = 1'b1;
    applyStimulus(0, 0, 32'h0, 32'h0); #2;
    checkOutput("start_after_rst", {31'b0, sram_ce_n}, 32'h0);
    waitIdle();

    // Directed store of 0xDEADBEEF at byte 1032 (half-words 4 and 5).
    applyStimulus(0, 1, 32'd1032, 32'hDEADBEEF); #2;
    checkOutput("wr_c0_ready", {31'b0, ready}, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 0, 32'h0, 32'h0); #2;
      checkOutput("wr_ready_lit", {31'b0, ready}, (c == 5) ? 32'h1 : 32'h0);
      if (c <= 4) begin
        checkOutput("wr_addr_lit", {14'b0, sram_addr}, (c <= 2) ? 32'd4 : 32'd5);
        checkOutput("wr_dq_lit", {16'b0, sram_dq}, (c <= 2) ? 32'hBEEF : 32'hDEAD);
        checkOutput("wr_we_lit", {31'b0, sram_we_n}, 32'h0);
      end
    end
    waitIdle();

    // Directed load of the same word.
    applyStimulus(1, 0, 32'd1032, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(0, 0, 32'h0, 32'h0); #2;
      if (c <= 4) checkOutput("rd_oe_lit", {30'b0, sram_oe_n, sram_we_n}, 32'h1);
      if (c == 5) begin
        checkOutput("rd_ready_lit", {31'b0, ready}, 32'h1);
        checkOutput("rd_data_lit", read_data, 32'hDEADBEEF);
      end
    end
    waitIdle();

    repeat (10) begin
      applyStimulus(0, 0, 32'h0, 32'h0); #2;
      checkOutput("idle_ready_lit", {31'b0, ready}, 32'h1);
      checkOutput("idle_ce_lit", {31'b0, sram_ce_n}, 32'h1);
    end

    // Collision (store wins), then a load of the same word back-to-back.
    applyStimulus(1, 1, 32'd1040, 32'h12345678);
    for (int c = 1; c <= 11; c++) begin
      applyStimulus((c == 5) || (c == 6), 0, 32'd1040, 32'h0); #2;
      if (c == 1) checkOutput("col_we_lit", {31'b0, sram_we_n}, 32'h0);
      if (c == 5) checkOutput("col_rd_kept_lit", read_data, 32'hDEADBEEF);
      if (c == 6) checkOutput("b2b_restart_lit", {31'b0, ready}, 32'h0);
      if (c == 7) checkOutput("b2b_oe_lit", {31'b0, sram_oe_n}, 32'h0);
      if (c == 11) begin
        checkOutput("b2b_ready_lit", {31'b0, ready}, 32'h1);
        checkOutput("b2b_data_lit", read_data, 32'h12345678);
      end
    end
    waitIdle();

    // Reset in the first high-half cycle of a store: only the low half lands.
    applyStimulus(0, 1, 32'd1048, 32'hAAAA5555);
    repeat (2) applyStimulus(0, 0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b0; #2;
    checkOutput("midrst_ctrl_lit", {29'b0, sram_we_n, sram_ce_n, sram_oe_n}, 32'h7);
    repeat (2) applyStimulus(0, 0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b1;
    applyStimulus(1, 0, 32'd1048, 32'h0);
    for (int c = 1; c <= 5; c++) applyStimulus(0, 0, 32'h0, 32'h0);
    #2 checkOutput("midrst_data_lit", read_data, 32'h00005555);
    waitIdle();

    // Random traffic; requests also toggle mid-access to show they are ignored.
    repeat (400) begin
      logic [31:0] a;
      a = BASE + 4 * $urandom_range(0, 13) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = BASE - 4 + $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 2) == 0, a, $urandom);
    end
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
